// File: rtl/game_pkg.sv
// Shared constants and types for the player sprite renderer.
package game_pkg;

    localparam int unsigned HV_W     = 10;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned BND_W    = 11;
    localparam int unsigned COL_W    = 5;
    localparam int unsigned ROW_W    = 6;
    localparam int unsigned RGB_W    = 12;

    localparam int unsigned SPR_W    = 32;
    localparam int unsigned SPR_H    = 48;
    localparam int unsigned SPR_HALF = 16;
    localparam int unsigned ANIM_DIV = 8;
    localparam int unsigned DIV_W    = $clog2(ANIM_DIV);
    localparam int unsigned SCR_W    = 640;
    localparam int unsigned SCR_H    = 480;
    localparam int unsigned RST_X    = 260;
    localparam int unsigned RST_Y    = 350;

    localparam logic [RGB_W-1:0] CLR_HEAD  = 12'hFC9;
    localparam logic [RGB_W-1:0] CLR_TORSO = 12'h0A4;
    localparam logic [RGB_W-1:0] CLR_LEGS  = 12'h631;

    typedef enum logic [1:0] {
        POSE_RUN0 = 2'd0,
        POSE_RUN1 = 2'd1,
        POSE_RUN2 = 2'd2,
        POSE_JUMP = 2'd3
    } pose_e;

    typedef struct packed {
        logic             valid;
        logic             in_box;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        pose_e            pose;
    } s1_t;

    function automatic logic in_rng(input logic [5:0] v, input logic [5:0] lo, input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sprite_shape.sv
// Combinational pose/row/col lookup: returns whether the sprite covers the cell and its colour.
module sprite_shape
    import game_pkg::*;
(
    input  pose_e            pose_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    output logic             on_c,
    output logic [RGB_W-1:0] rgb_c
);

    logic [5:0] c;
    logic       leg;

    assign c = {1'b0, col_i};

    always_comb begin
        on_c  = 1'b0;
        rgb_c = '0;
        leg   = 1'b0;
        if (row_i <= 6'd11) begin
            if (in_rng(c, 6'd10, 6'd21)) begin
                on_c  = 1'b1;
                rgb_c = CLR_HEAD;
            end
        end else if (row_i <= 6'd31) begin
            if (in_rng(c, 6'd8, 6'd23)) begin
                on_c  = 1'b1;
                rgb_c = CLR_TORSO;
            end
        end else begin
            case (pose_i)
                POSE_RUN0: leg = in_rng(c, 6'd8, 6'd13) || in_rng(c, 6'd18, 6'd23);
                POSE_RUN1: leg = in_rng(c, 6'd12, 6'd19);
                POSE_RUN2: leg = in_rng(c, 6'd4, 6'd9) || in_rng(c, 6'd22, 6'd27);
                default:   leg = (row_i <= 6'd39) && in_rng(c, 6'd8, 6'd23);
            endcase
            if (leg) begin
                on_c  = 1'b1;
                rgb_c = CLR_LEGS;
            end
        end
    end

endmodule

// File: rtl/player_renderer.sv
// Player sprite renderer: per-frame shadowed position/pose, 2-stage pixel pipeline.
module player_renderer
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [HV_W-1:0]  hcount,
    input  logic [HV_W-1:0]  vcount,
    input  logic             frame_start,
    input  logic [X_W-1:0]   player_x,
    input  logic [Y_W-1:0]   player_y,
    input  logic             jumping,
    output logic             pix_valid,
    output logic             pix_on,
    output logic [RGB_W-1:0] pix_rgb,
    output logic [1:0]       anim_frame
);

    logic [X_W-1:0]   sx_q, sx_d;
    logic [Y_W-1:0]   sy_q, sy_d;
    logic             jmp_q, jmp_d;
    logic [DIV_W-1:0] div_q, div_d;
    pose_e            pose_q, pose_d;
    s1_t              s1_q, s1_d;
    logic             pix_on_q, pix_valid_q;
    logic [RGB_W-1:0] pix_rgb_q;
    logic             shape_on_c;
    logic [RGB_W-1:0] shape_rgb_c;
    logic [BND_W-1:0] left_c, right_c, top_c, bot_c, h_c, v_c;

    // Shadow capture and animation divider; only frame_start changes anything.
    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        jmp_d  = jmp_q;
        div_d  = div_q;
        pose_d = pose_q;
        if (frame_start) begin
            sx_d  = player_x;
            sy_d  = player_y;
            jmp_d = jumping;
            if (jumping) begin
                div_d  = '0;
                pose_d = POSE_JUMP;
            end else if (jmp_q) begin
                div_d  = '0;
                pose_d = POSE_RUN0;
            end else begin
                div_d = DIV_W'(div_q + DIV_W'(1));
                if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                    pose_d = (pose_q == POSE_RUN2) ? POSE_RUN0 : pose_e'(2'(pose_q) + 2'd1);
                end
            end
        end
    end

    // Box bounds at 11 bits; bot_c is exclusive so sy=0 yields an empty box.
    always_comb begin
        h_c     = BND_W'(hcount);
        v_c     = BND_W'(vcount);
        left_c  = (sx_q < X_W'(SPR_HALF)) ? '0 : BND_W'(sx_q) - BND_W'(SPR_HALF);
        right_c = BND_W'(sx_q) + BND_W'(SPR_W - SPR_HALF - 1);
        top_c   = (sy_q < Y_W'(SPR_H)) ? '0 : BND_W'(sy_q) - BND_W'(SPR_H);
        bot_c   = BND_W'(sy_q);
        s1_d.valid  = pix_en;
        s1_d.in_box = (hcount < HV_W'(SCR_W)) && (vcount < HV_W'(SCR_H))
                   && (h_c >= left_c) && (h_c <= right_c)
                   && (v_c >= top_c) && (v_c < bot_c);
        s1_d.col  = COL_W'(h_c - left_c);
        s1_d.row  = ROW_W'(v_c - top_c);
        s1_d.pose = pose_q;
    end

    sprite_shape u_shape (
        .pose_i (s1_q.pose),
        .row_i  (s1_q.row),
        .col_i  (s1_q.col),
        .on_c   (shape_on_c),
        .rgb_c  (shape_rgb_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q        <= X_W'(RST_X);
            sy_q        <= Y_W'(RST_Y);
            jmp_q       <= 1'b0;
            div_q       <= '0;
            pose_q      <= POSE_RUN0;
            s1_q        <= '0;
            pix_on_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_rgb_q   <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            jmp_q       <= jmp_d;
            div_q       <= div_d;
            pose_q      <= pose_d;
            s1_q        <= s1_d;
            pix_valid_q <= s1_q.valid;
            pix_on_q    <= s1_q.in_box & shape_on_c;
            pix_rgb_q   <= (s1_q.in_box & shape_on_c) ? shape_rgb_c : '0;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_on     = pix_on_q;
    assign pix_rgb    = pix_rgb_q;
    assign anim_frame = 2'(pose_q);

endmodule

// File: tb/tb_player_renderer.sv
// Randomized scoreboard bench for player_renderer against a frame-level reference model.
module tb_player_renderer;

    logic        clk = 1'b0;
    logic        rst, pix_en, frame_start, jumping;
    logic [9:0]  hcount, vcount, player_x;
    logic [8:0]  player_y;
    logic        pix_valid, pix_on;
    logic [11:0] pix_rgb;
    logic [1:0]  anim_frame;

    player_renderer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .player_x(player_x), .player_y(player_y),
        .jumping(jumping), .pix_valid(pix_valid), .pix_on(pix_on),
        .pix_rgb(pix_rgb), .anim_frame(anim_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        logic [11:0] rgb;
        int          h;
        int          v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: latched player position, airborne flag, run pulses since reset/landing.
    int m_sx, m_sy, m_jmp, m_run;

    function automatic void model_reset();
        m_sx = 260; m_sy = 350; m_jmp = 0; m_run = 0;
    endfunction

    function automatic int model_pose();
        return (m_jmp != 0) ? 3 : (m_run / 8) % 3;
    endfunction

    function automatic void model_frame(input int x, input int y, input int j);
        if (j != 0) m_jmp = 1;
        else if (m_jmp != 0) begin m_jmp = 0; m_run = 0; end
        else m_run++;
        m_sx = x; m_sy = y;
    endfunction

    function automatic logic [11:0] shape(input int pose, input int r, input int c);
        if (r <= 11) return (c >= 10 && c <= 21) ? 12'hFC9 : 12'h000;
        if (r <= 31) return (c >= 8 && c <= 23) ? 12'h0A4 : 12'h000;
        case (pose)
            0: return ((c >= 8 && c <= 13) || (c >= 18 && c <= 23)) ? 12'h631 : 12'h000;
            1: return (c >= 12 && c <= 19) ? 12'h631 : 12'h000;
            2: return ((c >= 4 && c <= 9) || (c >= 22 && c <= 27)) ? 12'h631 : 12'h000;
            default: return (r <= 39 && c >= 8 && c <= 23) ? 12'h631 : 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] model_rgb(input int h, input int v);
        int left, right, top, bot;
        left  = (m_sx < 16) ? 0 : m_sx - 16;
        right = m_sx + 15;
        top   = (m_sy < 48) ? 0 : m_sy - 48;
        bot   = m_sy - 1;
        if (h >= 640 || v >= 480 || h < left || h > right || v < top || v > bot) return 12'h000;
        return shape(model_pose(), v - top, h - left);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One input cycle; expectation uses the state before this cycle's frame_start.
    task automatic cycle(input logic en, input int h, input int v, input logic fs);
        exp_t e;
        @(negedge clk);
        pix_en = en; hcount = 10'(h); vcount = 10'(v); frame_start = fs;
        if (en) begin
            e.rgb = model_rgb(h, v);
            e.on  = (e.rgb != 12'h000);
            e.h   = h; e.v = v;
            exp_q.push_back(e);
        end
        if (fs) model_frame(int'(player_x), int'(player_y), int'(jumping));
    endtask

    task automatic check_anim(input string name);
        @(negedge clk);
        pix_en = 1'b0; frame_start = 1'b0;
        check(name, int'(anim_frame), model_pose());
    endtask

    task automatic near_pix(input int n);
        int h, v;
        for (int i = 0; i < n; i++) begin
            h = m_sx - 20 + int'($urandom_range(0, 40));
            v = m_sy - 52 + int'($urandom_range(0, 56));
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            cycle(1'b1, h, v, 1'b0);
        end
    endtask

    // Monitor: pops one expectation for every valid output pixel.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && pix_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pix pix_valid=1 with empty scoreboard");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pix_on !== mon_e.on || pix_rgb !== mon_e.rgb) begin
                        miscompares++;
                        $display("FAIL pix(%0d,%0d) got on=%0b rgb=%03h exp on=%0b rgb=%03h",
                                 mon_e.h, mon_e.v, pix_on, pix_rgb, mon_e.on, mon_e.rgb);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, v, fs, en;
        rst = 1'b0; pix_en = 1'b0; frame_start = 1'b0; hcount = '0; vcount = '0;
        player_x = '0; player_y = '0; jumping = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_on", int'(pix_on), 0);
        check("rst_pix_rgb", int'(pix_rgb), 0);
        check("rst_anim", int'(anim_frame), 0);
        rst = 1'b1;

        // Centre lane, ground level
        player_x = 10'd260; player_y = 9'd350; jumping = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b1, 260, 330, 1'b0);
        cycle(1'b1, 244, 302, 1'b0);
        near_pix(40);

        // Mid-frame move is ignored until frame_start; same-cycle pixel uses old shadows
        player_x = 10'd380;
        cycle(1'b1, 380, 330, 1'b0);
        near_pix(10);
        cycle(1'b1, 380, 330, 1'b1);
        cycle(1'b1, 380, 330, 1'b0);

        // Running animation across 16 frames
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 0, 0, 1'b1);
            check_anim("run_anim");
            cycle(1'b1, m_sx - 16 + 5, m_sy - 48 + 40, 1'b0);
            near_pix(6);
        end

        // Jump then land
        jumping = 1'b1;
        cycle(1'b0, 0, 0, 1'b1);
        check_anim("jump_anim");
        for (int i = 0; i < 8; i++) cycle(1'b1, m_sx - 16 + int'($urandom_range(0, 31)), m_sy - 48 + 44, 1'b0);
        near_pix(10);
        jumping = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);
        check_anim("land_anim");
        near_pix(10);

        // Clamped box near the top-left corner and off-screen columns
        player_x = 10'd10; player_y = 9'd30;
        cycle(1'b0, 0, 0, 1'b1);
        check_anim("edge_anim");
        cycle(1'b1, 639, 10, 1'b0);
        cycle(1'b1, 700, 10, 1'b0);
        cycle(1'b1, 639, 479, 1'b0);
        cycle(1'b1, 25, 29, 1'b0);
        cycle(1'b1, 26, 29, 1'b0);
        cycle(1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0);

        // Random frames, positions and pixels
        for (int i = 0; i < 600; i++) begin
            fs = ($urandom_range(0, 15) == 0) ? 1 : 0;
            if (fs != 0) begin
                case ($urandom_range(0, 3))
                    0: player_x = 10'd140;
                    1: player_x = 10'd260;
                    2: player_x = 10'd380;
                    default: player_x = 10'($urandom_range(0, 1023));
                endcase
                player_y = ($urandom_range(0, 1) == 0) ? 9'd350 : 9'($urandom_range(0, 511));
                jumping  = ($urandom_range(0, 3) == 0);
            end
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if ($urandom_range(0, 1) == 0) begin
                h = m_sx - 20 + int'($urandom_range(0, 40));
                v = m_sy - 52 + int'($urandom_range(0, 56));
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                if (h > 1023) h = 1023;
                if (v > 1023) v = 1023;
            end else begin
                h = int'($urandom_range(0, 1023));
                v = int'($urandom_range(0, 1023));
            end
            cycle(1'(en), h, v, 1'(fs));
            if (fs != 0) check_anim("rand_anim");
        end

        // Asynchronous reset while the sprite is being drawn
        player_x = 10'd260; player_y = 9'd350; jumping = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);
        repeat (3) cycle(1'b1, 260, 330, 1'b0);
        @(negedge clk);
        pix_en = 1'b0;
        check("pre_rst_pix_on", int'(pix_on), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pix_on", int'(pix_on), 0);
        check("async_rst_pix_valid", int'(pix_valid), 0);
        check("async_rst_pix_rgb", int'(pix_rgb), 0);
        check("async_rst_anim", int'(anim_frame), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_anim("post_rst_anim");
        near_pix(30);

        repeat (4) cycle(1'b0, 0, 0, 1'b0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/player_renderer.md
PLAYER_RENDERER -- requirements
Module: player_renderer

Interface
REQ-001 SHALL have port clk, input, 1, system clock (all logic on rising edge).
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port pix_en, input, 1, pixel strobe; one pixel per pulse.
REQ-004 SHALL have port hcount, input, 10, current pixel column.
REQ-005 SHALL have port vcount, input, 10, current pixel row.
REQ-006 SHALL have port frame_start, input, 1, single-cycle pulse once per frame during vertical blanking.
REQ-007 SHALL have port player_x, input, 10, player horizontal centre from the player block (lanes 140/260/380).
REQ-008 SHALL have port player_y, input, 9, player foot baseline from the player block (350 = ground).
REQ-009 SHALL have port jumping, input, 1, high while the player is airborne.
REQ-010 SHALL have port pix_valid, output, 1, delayed copy of pix_en.
REQ-011 SHALL have port pix_on, output, 1, sprite covers this pixel.
REQ-012 SHALL have port pix_rgb, output, 12, RGB444 sprite colour; 0 when pix_on=0.
REQ-013 SHALL have port anim_frame, output, 2, current pose code.

Function
REQ-014 SHALL capture player_x, player_y and jumping into shadow registers only on a cycle with frame_start=1; shadows are held for the rest of the frame (no mid-frame tearing).
REQ-015 SHALL define the sprite box as 32 wide x 48 tall: columns sx-16..sx+15, rows sy-48..sy-1 (sx, sy = shadows).
REQ-016 SHALL clamp the box to 0 when sx<16 or sy<48 (no unsigned wrap); SHALL compute box bounds at 11 bits so that sx+15 never overflows.
REQ-017 SHALL force pix_on=0 for hcount>=640 or vcount>=480.
REQ-018 SHALL use a 2-stage pipeline advancing every clk: stage 1 registers in_box, col=hcount-left (5b), row=vcount-top (6b), pix_en; stage 2 registers pix_on, pix_rgb, pix_valid; latency exactly 2 clk.
REQ-019 SHALL define the shape per pose: head rows 0-11 cols 10-21 colour 12'hFC9; torso rows 12-31 cols 8-23 colour 12'h0A4; legs colour 12'h631.
REQ-020 SHALL define the legs per pose: pose 0 rows 32-47 cols 8-13 and 18-23; pose 1 rows 32-47 cols 12-19; pose 2 rows 32-47 cols 4-9 and 22-27; pose 3 (jump) rows 32-39 cols 8-23.
REQ-021 SHALL count frame_start pulses in a 3-bit divider; on divider wrap 7->0, anim_frame SHALL advance 0->1->2->0 (pose 3 never reached by running).
REQ-022 SHALL set anim_frame=3 and hold the divider at 0 while shadow jumping=1; on the first frame with shadow jumping=0, anim_frame SHALL be 0.
REQ-023 SHALL apply frame_start and pix_en arriving in the same cycle such that the pixel sampled in that cycle uses the old shadows, and the new shadows take effect from the next cycle.

Reset
REQ-024 SHALL, while rst=0, set shadow x=260, shadow y=350, shadow jumping=0, divider=0, anim_frame=0, and all pipeline registers (pix_valid, pix_on, pix_rgb)=0.
REQ-025 SHALL discard in-flight pipeline data on reset mid-frame; the first output after release is valid only after 2 clk of pix_en.

Structure
REQ-026 SHALL place sprite constants (width 32, height 48, half-width 16, colour values, ANIM_DIV=8, screen limits 640/480) in shared package game_pkg.
REQ-027 SHALL implement the pose/row/col to on/colour mapping as combinational sub-module sprite_shape instantiated in stage 2.

Verification
REQ-028 Reset release, frame_start with x=260, y=350: pixel (260,330) -> pix_on=1, rgb=12'h0A4 2 clk after pix_en; pixel (244,302) -> rgb=12'hFC9 absent (col 0 outside head) -> pix_on=0.
REQ-029 Mid-frame player_x change 260->380 without frame_start: pixel (380,330) -> pix_on=0 until the next frame_start, then pix_on=1.
REQ-030 16 frame_start pulses, jumping=0: anim_frame 0->1 after 8 pulses, ->2 after 16; pixel (row 40, col 5) on only in pose 2.
REQ-031 jumping=1 at frame_start: anim_frame=3, leg row 44 off; jumping=0 at next frame_start -> anim_frame=0.
REQ-032 x=10, y=30 edge case: box clamped to cols 0..25, rows 0..29; hcount=639 and hcount=700 -> pix_on=0, no wrap artefacts.
REQ-033 rst=0 mid-frame while pix_on=1 -> pix_on, pix_valid, pix_rgb=0 immediately (asynchronous); anim_frame=0.
